ex_flag_branch_unit: RTL
========================

Name: ex_flag_branch_unit

Overview:
- Execute-stage back end sitting directly downstream of the 16-bit ALU.
- Consumes the ALU result and its zero/neg/grt/eq flags each instruction, and holds them in an architectural status register.
- Resolves conditional branches against that status register and squashes wrong-path instructions.
- Buffers results in a 2-entry queue toward writeback behind a valid/ready handshake.

Parameters:
DATA_WIDTH, 16, width of result, branch target and queue data
DEST_WIDTH, 3, register-file destination index width
SQUASH_CYCLES, 2, cycles of wrong-path drop after a taken branch; 0 disables squash

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  ALU-stage instruction valid
in_ready  out  1  unit accepts this cycle
in_result  in  DATA_WIDTH  ALU result
in_zero  in  1  ALU zero flag
in_neg  in  1  ALU neg flag
in_grt  in  1  ALU grt flag
in_eq  in  1  ALU eq flag
in_set_flags  in  1  instruction updates status register
in_br_cond  in  3  branch condition, br_cond_t
in_br_target  in  DATA_WIDTH  branch target PC
in_dest  in  DEST_WIDTH  writeback register index
in_wr_en  in  1  instruction writes the register file
out_valid  out  1  queue head valid
out_ready  in  1  writeback accepts head
out_result  out  DATA_WIDTH  head result
out_dest  out  DEST_WIDTH  head destination
out_wr_en  out  1  head write enable
status  out  4  {Z,N,G,E} architectural flags
redirect_valid  out  1  one-cycle taken-branch pulse
redirect_pc  out  DATA_WIDTH  redirect target
perf_retired  out  16  retired count (see feature)
perf_squashed  out  16  squashed count (see feature)

Behaviour:
- Reset (async, rst_n=0):
  - queue empty; out_valid=0; out_result/out_dest/out_wr_en=0.
  - status=0; redirect_valid=0; redirect_pc=0.
  - FSM=RUN; squash counter=0; perf counters=0.
  - Reset mid-squash or with a pending redirect cancels both.
- Accept = in_valid && in_ready.
- in_ready:
  - RUN: in_ready = (count<2).
  - SQUASH: in_ready = 1; inputs are consumed and dropped.
- Queue:
  - 2-entry FIFO of {result,dest,wr_en}; out_valid = (count!=0); pop on out_valid && out_ready.
  - Simultaneous push and pop at count 1 keeps count 1 and preserves order.
  - At count 2, in_ready is low, so no push occurs.
  - Zero-bubble: an entry pushed at edge t is visible at the head from t.
  - Head fields stay stable while out_valid && !out_ready.
- Status register:
  - On an accepted, non-squashed instruction with in_set_flags=1, status <= {in_zero,in_neg,in_grt,in_eq} at that edge.
  - Otherwise status is held.
- Branch evaluation:
  - At acceptance in RUN, using the registered status value (the flags of earlier flag-setters only, never the same instruction's flags).
  - Conditions (br_cond_t): BR_NONE=0 never taken; BR_EQ: E; BR_NE: !E; BR_GT: G; BR_LT: N; BR_Z: Z; BR_ALWAYS=6 always taken; 7 reserved, treated as BR_NONE.
  - Branch instructions still enqueue normally (wr_en as supplied).
- Taken branch accepted at edge t:
  - redirect_valid=1 and redirect_pc=in_br_target during cycle t+1 only.
  - If SQUASH_CYCLES>0: FSM RUN->SQUASH at t with counter=SQUASH_CYCLES; each cycle in SQUASH decrements the counter; SQUASH->RUN when it reaches 0.
  - Exactly SQUASH_CYCLES cycles drop input, counted whether or not in_valid is high.
  - Queue drains normally during SQUASH.
- Dropped instructions: no enqueue, no status update, no redirect, even if they are taken branches.
- SQUASH_CYCLES=0: FSM stays in RUN; redirect still pulses.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- Defined:
  - perf_retired increments on each pop; perf_squashed increments on each dropped accept.
  - Both are 16-bit and wrap 0xFFFF->0.
- Undefined: both outputs constant 0; no counter flops.

Decomposition:
- Package ex_pkg:
  - br_cond_t enum (3-bit values above).
  - ex_state_t {RUN,SQUASH}.
  - queue entry struct.
  - STATUS_Z/N/G/E bit-index constants.
- Sub-module ex_skid_fifo: the 2-entry queue, parameterised by entry width.
- Condition evaluation and FSM stay in the top module.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 mid-squash with queue count 2.
  - Response: out_valid=0, status=0, redirect_valid=0, in_ready=1 on release.
- Backpressure:
  - Stimulus: push results 0x0011, 0x0022, 0x0033 with out_ready=0.
  - Response: in_ready=0 after two pushes; raising out_ready yields 0x0011, 0x0022, 0x0033 in order.
- Flag ordering:
  - Stimulus: accept CMP with eq=1 and set_flags=1, followed back-to-back by BR_EQ target 0x0100.
  - Response: status=4'b0001 before the branch; redirect_valid pulses once with redirect_pc=0x0100.
- Same-instruction flags ignored:
  - Stimulus: status E=0, then accept BR_EQ carrying in_eq=1 and set_flags=1.
  - Response: not taken; status becomes E=1 afterwards.
- Squash:
  - Stimulus: SQUASH_CYCLES=2; BR_ALWAYS taken, then three valid instructions including a taken BR_ALWAYS.
  - Response: first two are dropped with no redirect; third is enqueued; perf_squashed=2 when EX_PERF_CNT_EN is defined.
- Counter wrap:
  - Stimulus: with EX_PERF_CNT_EN defined, preset perf_retired to 0xFFFF via force and pop once.
  - Response: perf_retired=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the execute-stage flag/branch back end: branch condition
// codes, FSM states, queue entry layout, status bit positions and the branch
// condition evaluator.
package ex_pkg;

  localparam int EX_DATA_W = 16;
  localparam int EX_DEST_W = 3;

  // Bit positions inside the {Z,N,G,E} status register
  localparam int STATUS_Z = 3;
  localparam int STATUS_N = 2;
  localparam int STATUS_G = 1;
  localparam int STATUS_E = 0;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_GT     = 3'd3,
    BR_LT     = 3'd4,
    BR_Z      = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_RSVD   = 3'd7
  } br_cond_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } ex_state_t;

  // Writeback queue entry at default widths; the top packs the same field
  // order {result, dest, wr_en} into a flat vector sized by its parameters.
  typedef struct packed {
    logic [EX_DATA_W-1:0] result;
    logic [EX_DEST_W-1:0] dest;
    logic                 wr_en;
  } ex_entry_t;

  // Resolve a branch condition against the architectural status flags.
  // The reserved encoding behaves like BR_NONE.
  function automatic logic br_eval(input br_cond_t cond, input logic [3:0] st);
    logic taken;
    case (cond)
      BR_NONE:   taken = 1'b0;
      BR_EQ:     taken = st[STATUS_E];
      BR_NE:     taken = ~st[STATUS_E];
      BR_GT:     taken = st[STATUS_G];
      BR_LT:     taken = st[STATUS_N];
      BR_Z:      taken = st[STATUS_Z];
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_skid_fifo.sv
// Two-entry queue toward writeback. The head lives in its own register so a
// push into an empty queue is visible at the head right after the edge, and
// head contents never move while the head is not popped.
module ex_skid_fifo #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       count_r;

  // Head/tail storage and occupancy; push into a full queue is blocked upstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r  <= push_data;
            count_r <= 2'd1;
          end else if (count_r == 2'd1) begin
            tail_r  <= push_data;
            count_r <= 2'd2;
          end else begin
            count_r <= count_r;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_r  <= tail_r;
            count_r <= 2'd1;
          end else if (count_r == 2'd1) begin
            count_r <= 2'd0;
          end else begin
            count_r <= count_r;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= push_data;
          end else begin
            // count 1: the new entry replaces the departing head; count 0
            // cannot pop, so this only ever sees count 1 in practice
            head_r  <= push_data;
            count_r <= 2'd1;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head_data = head_r;
  assign count     = count_r;

endmodule

// File: rtl/ex_flag_branch_unit.sv
// Execute-stage back end behind the ALU: holds the {Z,N,G,E} status register,
// resolves conditional branches against it, drops wrong-path instructions for
// SQUASH_CYCLES cycles after a taken branch, and queues results to writeback.
// Optional: define EX_PERF_CNT_EN to build the retired/squashed counters;
// otherwise perf_retired and perf_squashed are tied to zero.
module ex_flag_branch_unit
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DEST_WIDTH    = 3,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_zero,
  input  logic                  in_neg,
  input  logic                  in_grt,
  input  logic                  in_eq,
  input  logic                  in_set_flags,
  input  logic [2:0]            in_br_cond,
  input  logic [DATA_WIDTH-1:0] in_br_target,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_wr_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_wr_en,
  output logic [3:0]            status,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [15:0]           perf_retired,
  output logic [15:0]           perf_squashed
);

  localparam int ENTRY_W = DATA_WIDTH + DEST_WIDTH + 1;
  localparam int CNT_W   = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_CYCLES);

  ex_state_t             state_r;
  ex_state_t             state_nxt_s;
  logic [CNT_W-1:0]      sq_cnt_r;
  logic [CNT_W-1:0]      sq_cnt_nxt_s;
  logic [3:0]            status_r;
  logic                  redirect_valid_r;
  logic [DATA_WIDTH-1:0] redirect_pc_r;
  logic [1:0]            fifo_count_s;
  logic [ENTRY_W-1:0]    head_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  live_s;
  logic                  taken_s;
  logic                  pop_s;

  // Input handshake: wrong-path cycles swallow everything, otherwise wait for queue room
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == SQUASH) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = (fifo_count_s != 2'd2);
    end
  end

  assign accept_s = in_valid && in_ready_s;
  assign live_s   = accept_s && (state_r == RUN);
  // Status is the registered value, so a flag-setting branch never sees its own flags
  assign taken_s  = live_s && br_eval(br_cond_t'(in_br_cond), status_r);
  assign pop_s    = (fifo_count_s != 2'd0) && out_ready;

  ex_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (live_s),
    .pop      (pop_s),
    .push_data({in_result, in_dest, in_wr_en}),
    .head_data(head_s),
    .count    (fifo_count_s)
  );

  // Next-state logic: a taken branch opens a fixed-length drop window
  always_comb begin
    state_nxt_s  = state_r;
    sq_cnt_nxt_s = sq_cnt_r;
    case (state_r)
      RUN: begin
        if (taken_s && (SQUASH_CYCLES > 0)) begin
          state_nxt_s  = SQUASH;
          sq_cnt_nxt_s = SQ_LOAD;
        end else begin
          state_nxt_s  = RUN;
          sq_cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      SQUASH: begin
        sq_cnt_nxt_s = sq_cnt_r - CNT_W'(1);
        if (sq_cnt_r <= CNT_W'(1)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SQUASH;
        end
      end
      default: begin
        state_nxt_s  = RUN;
        sq_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and squash countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      sq_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      sq_cnt_r <= sq_cnt_nxt_s;
    end
  end

  // Architectural status: only accepted, on-path flag setters update it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r <= 4'b0000;
    end else if (live_s && in_set_flags) begin
      status_r <= {in_zero, in_neg, in_grt, in_eq};
    end else begin
      status_r <= status_r;
    end
  end

  // One-cycle redirect pulse; the target is kept until the next taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      redirect_valid_r <= taken_s;
      if (taken_s) begin
        redirect_pc_r <= in_br_target;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = (fifo_count_s != 2'd0);
  assign out_result     = head_s[ENTRY_W-1 -: DATA_WIDTH];
  assign out_dest       = head_s[DEST_WIDTH:1];
  assign out_wr_en      = head_s[0];
  assign status         = status_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

`ifdef EX_PERF_CNT_EN
  logic [15:0] perf_retired_r;
  logic [15:0] perf_squashed_r;
  logic        drop_s;

  assign drop_s = accept_s && (state_r == SQUASH);

  // Free-running event counters; wrap naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_r  <= 16'd0;
      perf_squashed_r <= 16'd0;
    end else begin
      if (pop_s) begin
        perf_retired_r <= perf_retired_r + 16'd1;
      end else begin
        perf_retired_r <= perf_retired_r;
      end
      if (drop_s) begin
        perf_squashed_r <= perf_squashed_r + 16'd1;
      end else begin
        perf_squashed_r <= perf_squashed_r;
      end
    end
  end

  assign perf_retired  = perf_retired_r;
  assign perf_squashed = perf_squashed_r;
`else
  assign perf_retired  = 16'd0;
  assign perf_squashed = 16'd0;
`endif

endmodule
